// File: rtl/filtro_pkg.sv
// Shared types and arithmetic helpers for the biquad cascade.
package filtro_pkg;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE,
    DONE
  } state_t;

  // Five 2W-bit products need three guard bits above the product width.
  localparam int ACC_GUARD = 3;

  function automatic int acc_width(input int w);
    return 2 * w + ACC_GUARD;
  endfunction

  // Round half up at bit f, then clamp to the signed w-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int w, input int f);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (f - 1))) >>> f;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/biquad_mac_sat.sv
// Shared signed multiply-accumulate with round/saturate output.
module biquad_mac_sat
  import filtro_pkg::*;
#(
  parameter int W = 25,
  parameter int F = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                sub,
  input  logic signed [W-1:0] coef,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] result
);

  localparam int ACC_W = acc_width(W);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;

  assign prod     = coef * sample;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? acc - prod_ext : acc + prod_ext;
    end
  end

  assign result = W'(round_sat(64'(acc), W, F));

endmodule

// File: rtl/filtro_biquad_cascada.sv
// Cascade of N_SEC direct-form-I biquads sharing one MAC, one sample per Enable.
module filtro_biquad_cascada
  import filtro_pkg::*;
#(
  parameter int W     = 25,
  parameter int F     = 10,
  parameter int N_SEC = 2
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         Enable,
  input  logic signed [W-1:0]          u,
  input  logic [N_SEC-1:0]             Bypass,
  input  logic                         Coef_WE,
  input  logic [$clog2(5*N_SEC)-1:0]   Coef_Addr,
  input  logic signed [W-1:0]          Coef_Data,
  output logic signed [W-1:0]          y,
  output logic                         Valid,
  output logic                         Busy,
  output logic                         Overrun
);

  localparam int NCOEF = 5 * N_SEC;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam logic signed [W-1:0] UNITY = W'(1 << F);

  logic signed [W-1:0] coef [NCOEF];
  logic signed [W-1:0] x1 [N_SEC];
  logic signed [W-1:0] x2 [N_SEC];
  logic signed [W-1:0] y1 [N_SEC];
  logic signed [W-1:0] y2 [N_SEC];

  state_t              state;
  coef_idx_t           idx;
  logic [SW-1:0]       sec;
  logic [N_SEC-1:0]    byp;
  logic signed [W-1:0] sec_x;
  logic signed [W-1:0] mul_coef;
  logic signed [W-1:0] mul_sample;
  logic signed [W-1:0] sec_res;
  logic signed [W-1:0] sec_out;
  logic [AW-1:0]       coef_sel;
  logic                mac_clr;
  logic                mac_en;
  logic                mac_sub;

  assign coef_sel = AW'(5 * int'(sec) + int'(idx));
  assign mac_clr  = (state == IDLE) || (state == STORE);
  assign mac_en   = (state == MAC);
  assign mac_sub  = (idx == A1) || (idx == A2);
  assign sec_out  = byp[sec] ? sec_x : sec_res;

  always_comb begin
    mul_coef   = coef[coef_sel];
    mul_sample = sec_x;
    case (idx)
      B1:      mul_sample = x1[sec];
      B2:      mul_sample = x2[sec];
      A1:      mul_sample = y1[sec];
      A2:      mul_sample = y2[sec];
      default: mul_sample = sec_x;
    endcase
  end

  biquad_mac_sat #(.W(W), .F(F)) u_mac (
    .clk    (CLK),
    .rst    (Reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .sub    (mac_sub),
    .coef   (mul_coef),
    .sample (mul_sample),
    .result (sec_res)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NCOEF; i++)
        coef[AW'(i)] <= (i % 5 == 0) ? UNITY : '0;
      for (int unsigned i = 0; i < N_SEC; i++) begin
        x1[SW'(i)] <= '0;
        x2[SW'(i)] <= '0;
        y1[SW'(i)] <= '0;
        y2[SW'(i)] <= '0;
      end
      state   <= IDLE;
      idx     <= B0;
      sec     <= '0;
      byp     <= '0;
      sec_x   <= '0;
      y       <= '0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (Enable && Busy)
        Overrun <= 1'b1;
      if (Coef_WE && !Busy && (int'(Coef_Addr) < NCOEF))
        coef[Coef_Addr] <= Coef_Data;

      case (state)
        IDLE: begin
          if (Enable) begin
            state <= MAC;
            Busy  <= 1'b1;
            sec   <= '0;
            idx   <= B0;
            sec_x <= u;
            byp   <= Bypass;
          end
        end
        MAC: begin
          if (idx == A2) state <= STORE;
          else           idx   <= coef_idx_t'(idx + 3'd1);
        end
        STORE: begin
          // A bypassed section still burns its slot but leaves its history intact.
          if (!byp[sec]) begin
            x2[sec] <= x1[sec];
            x1[sec] <= sec_x;
            y2[sec] <= y1[sec];
            y1[sec] <= sec_res;
          end
          sec_x <= sec_out;
          if (sec == SW'(N_SEC - 1)) begin
            y     <= sec_out;
            Valid <= 1'b1;
            state <= DONE;
          end else begin
            sec   <= sec + 1'b1;
            idx   <= B0;
            state <= MAC;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_biquad_cascada.sv
// Scoreboard bench for the biquad cascade against an arithmetic reference model.
module tb_filtro_biquad_cascada;

  localparam int W   = 25;
  localparam int F   = 10;
  localparam int N   = 2;
  localparam int NC  = 5 * N;
  localparam int AW  = $clog2(NC);
  localparam int LAT = 6 * N + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b0;
  logic                we  = 1'b0;
  logic signed [W-1:0] u_in  = '0;
  logic signed [W-1:0] cdata = '0;
  logic [N-1:0]        byp   = '0;
  logic [AW-1:0]       caddr = '0;
  logic signed [W-1:0] y;
  logic                valid;
  logic                busy;
  logic                ovr;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  filtro_biquad_cascada #(.W(W), .F(F), .N_SEC(N)) dut (
    .CLK       (clk),
    .Reset     (rst),
    .Enable    (en),
    .u         (u_in),
    .Bypass    (byp),
    .Coef_WE   (we),
    .Coef_Addr (caddr),
    .Coef_Data (cdata),
    .y         (y),
    .Valid     (valid),
    .Busy      (busy),
    .Overrun   (ovr)
  );

  typedef struct {
    longint val;
    int     cyc;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  longint mc [N][5];
  longint mx1 [N];
  longint mx2 [N];
  longint my1 [N];
  longint my2 [N];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < 5; k++) mc[s][k] = (k == 0) ? (64'sd1 <<< F) : 0;
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic longint model_run(input longint x_in, input logic [N-1:0] bp);
    longint x, acc, r, hi, lo;
    x  = x_in;
    hi = (64'sd1 <<< (W - 1)) - 1;
    lo = -(64'sd1 <<< (W - 1));
    for (int s = 0; s < N; s++) begin
      if (bp[s]) continue;
      acc = mc[s][0] * x + mc[s][1] * mx1[s] + mc[s][2] * mx2[s]
          - mc[s][3] * my1[s] - mc[s][4] * my2[s];
      r = (acc + (64'sd1 <<< (F - 1))) >>> F;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      mx2[s] = mx1[s]; mx1[s] = x;
      my2[s] = my1[s]; my1[s] = r;
      x = r;
    end
    return x;
  endfunction

  // Monitor: every Valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got Valid=1 with y=%0d, expected no Valid (cycle %0d)", y, cyc);
      end else begin
        e = sbq.pop_front();
        check("y", longint'(y), e.val);
        check("latency", longint'(cyc - e.cyc), LAT);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic wcoef(input int addr, input longint data, input bit apply);
    we    = 1'b1;
    caddr = AW'(addr);
    cdata = W'(data);
    tick();
    we = 1'b0;
    if (apply && addr < NC) mc[addr / 5][addr % 5] = data;
  endtask

  task automatic send(input longint uval, input logic [N-1:0] bp, input bit push,
                      input bit cwe, input int addr, input longint data, output int start);
    exp_t e;
    en    = 1'b1;
    u_in  = W'(uval);
    byp   = bp;
    we    = cwe;
    caddr = AW'(addr);
    cdata = W'(data);
    if (cwe && addr < NC) mc[addr / 5][addr % 5] = data;
    start = cyc;
    if (push) begin
      e.val = model_run(uval, bp);
      e.cyc = start;
      sbq.push_back(e);
    end
    tick();
    en = 1'b0;
    we = 1'b0;
  endtask

  task automatic complete(input int start);
    int n;
    check("busy_high", longint'(busy), 1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("busy_len", longint'(cyc - start), LAT + 1);
  endtask

  task automatic run(input longint uval, input logic [N-1:0] bp);
    int s;
    send(uval, bp, 1'b1, 1'b0, 0, 0, s);
    complete(s);
  endtask

  initial begin
    int s;
    model_reset();
    do_reset();
    check("rst_y", longint'(y), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(ovr), 0);

    // identity after reset
    run(1000, '0);
    check("overrun_clear", longint'(ovr), 0);

    // half gain in section 0, rounding of a negative half
    wcoef(0, 512, 1'b1);
    run(2000, '0);
    run(-3, '0);

    // single-pole recursion in section 0, section 1 bypassed
    do_reset();
    wcoef(0, 1024, 1'b1);
    wcoef(3, -512, 1'b1);
    run(1024, 2'b10);
    repeat (3) run(0, 2'b10);

    // saturation at both rails
    do_reset();
    wcoef(0, 4096, 1'b1);
    wcoef(5, 4096, 1'b1);
    run(longint'(1) <<< 22, '0);
    run(-(longint'(1) <<< 22), '0);

    // overrun and dropped coefficient write while busy
    do_reset();
    send(500, '0, 1'b1, 1'b0, 0, 0, s);
    tick();
    tick();
    en   = 1'b1;
    u_in = W'(777);
    tick();
    en = 1'b0;
    check("overrun_set", longint'(ovr), 1);
    wcoef(0, 0, 1'b0);
    complete(s);
    check("overrun_held", longint'(ovr), 1);
    run(100, '0);
    check("overrun_sticky", longint'(ovr), 1);

    // reset in the middle of a computation
    run(1234, '0);
    send(999, '0, 1'b0, 1'b0, 0, 0, s);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_y", longint'(y), 0);
    check("abort_valid", longint'(valid), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_overrun", longint'(ovr), 0);
    rst = 1'b0;
    model_reset();
    repeat (20) tick();
    run(-4321, '0);

    // randomized coefficients, bypass masks, samples and same-cycle writes
    do_reset();
    for (int i = 0; i < 40; i++) begin
      longint uv, cd;
      int     ca;
      bit     cw;
      if ($urandom_range(0, 2) == 0)
        wcoef(int'($urandom_range(0, 15)), longint'($urandom_range(0, 3000)) - 1500, 1'b1);
      cw = ($urandom_range(0, 3) == 0);
      ca = int'($urandom_range(0, 15));
      cd = longint'($urandom_range(0, 3000)) - 1500;
      uv = longint'($urandom_range(0, 2 * (1 << 20))) - (1 << 20);
      send(uv, N'($urandom_range(0, 3)), 1'b1, cw, ca, cd, s);
      complete(s);
    end

    repeat (3) tick();
    check("queue_empty", longint'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
